// File: rtl/trng_word_ctrl.sv
// Post-processing controller for the TRNG core: warm-up discard, repetition-count
// health test, LSB-first word packing and a small output FIFO with alarm/reseed.
module trng_word_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int WARMUP    = 64,
    parameter int RCT_LIMIT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_en,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               drop_cnt,
    output logic                     alarm,
    input  logic                     alarm_clr,
    output logic                     reseed_req
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int BC_W   = $clog2(WIDTH);
    localparam int WC_W   = $clog2(WARMUP + 1) + 1;
    localparam int RC_W   = $clog2(RCT_LIMIT + 1);

    localparam logic [WC_W-1:0]   WARM_LAST = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(WIDTH - 1);
    localparam logic [RC_W-1:0]   RCT_MAX   = RC_W'(RCT_LIMIT);
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WARM    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_ALARM   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WC_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [RC_W-1:0]   rct_q, rct_d, rct_next;
    logic              prev_q, prev_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        drop_q, drop_d;
    logic              alarm_q, alarm_d;
    logic              reseed_q, reseed_d;
    logic              word_done, flush, pop, push;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rct_d      = rct_q;
        rct_next   = rct_q;
        prev_d     = prev_q;
        alarm_d    = alarm_q;
        reseed_d   = 1'b0;
        word_done  = 1'b0;
        flush      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_en) state_d = (WARMUP == 0) ? S_COLLECT : S_WARM;
            end
            S_WARM: begin
                if (!run_en) begin
                    state_d    = S_IDLE;
                    warm_cnt_d = '0;
                end else if (bit_valid) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d    = S_COLLECT;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WC_W'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (!run_en) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    rct_d     = '0;
                end else if (bit_valid) begin
                    // A zero count marks the first bit since entering COLLECT
                    rct_next = (rct_q == '0 || bit_in != prev_q) ? RC_W'(1) : rct_q + RC_W'(1);
                    prev_d   = bit_in;
                    if (rct_next == RCT_MAX) begin
                        state_d   = S_ALARM;
                        alarm_d   = 1'b1;
                        reseed_d  = 1'b1;
                        flush     = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        rct_d     = '0;
                    end else begin
                        rct_d   = rct_next;
                        shift_d = {bit_in, shift_q[WIDTH-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            word_done = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end
                end
            end
            S_ALARM: begin
                if (alarm_clr) begin
                    state_d = S_IDLE;
                    alarm_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        drop_d   = drop_q;
        pop      = (fill_q != '0) && out_ready;
        push     = word_done && ((fill_q != FULL) || pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) begin
                mem_d[wr_ptr_q] = shift_d;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (push && !pop)      fill_d = fill_q + FILL_W'(1);
            else if (pop && !push) fill_d = fill_q - FILL_W'(1);
            if (word_done && !push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rct_q      <= '0;
            prev_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            drop_q     <= '0;
            alarm_q    <= 1'b0;
            reseed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rct_q      <= rct_d;
            prev_q     <= prev_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            drop_q     <= drop_d;
            alarm_q    <= alarm_d;
            reseed_q   <= reseed_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid  = (fill_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill       = fill_q;
    assign drop_cnt   = drop_q;
    assign alarm      = alarm_q;
    assign reseed_req = reseed_q;

endmodule

// File: tb/tb_trng_word_ctrl.sv
// Self-checking bench for trng_word_ctrl: a cycle model builds the expected word
// queue as bits are driven; the queue head is compared whenever the DUT presents data.
module tb_trng_word_ctrl;

    localparam int W     = 8;
    localparam int D     = 4;
    localparam int WU    = 4;
    localparam int LIMIT = 16;

    localparam int M_IDLE    = 0;
    localparam int M_WARM    = 1;
    localparam int M_COLLECT = 2;
    localparam int M_ALARM   = 3;

    logic         clk = 1'b0;
    logic         rst, run_en, bit_in, bit_valid, out_ready, alarm_clr;
    logic [W-1:0] out_data;
    logic         out_valid, alarm, reseed_req;
    logic [2:0]   fill;
    logic [7:0]   drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    int           m_state, m_wcnt, m_bcnt, m_rct, m_drop;
    logic         m_prev, m_alarm, m_reseed;
    logic [W-1:0] m_word;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sent[5];
    logic [W-1:0] prior_word;

    trng_word_ctrl #(.WIDTH(W), .DEPTH(D), .WARMUP(WU), .RCT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .run_en(run_en), .bit_in(bit_in), .bit_valid(bit_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fill(fill),
        .drop_cnt(drop_cnt), .alarm(alarm), .alarm_clr(alarm_clr), .reseed_req(reseed_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one clock edge using the inputs currently driven
    task automatic modelEdge();
        logic pop, done;
        int   rct_new;
        if (rst) begin
            m_state = M_IDLE; m_wcnt = 0; m_bcnt = 0; m_rct = 0; m_drop = 0;
            m_prev = 1'b0; m_alarm = 1'b0; m_reseed = 1'b0; m_word = '0;
            exp_q.delete();
            return;
        end
        m_reseed = 1'b0;
        pop  = (exp_q.size() > 0) && out_ready;
        done = 1'b0;
        case (m_state)
            M_IDLE: if (run_en) m_state = M_WARM;
            M_WARM: begin
                if (!run_en) begin m_state = M_IDLE; m_wcnt = 0; end
                else if (bit_valid) begin
                    if (m_wcnt == WU - 1) begin m_state = M_COLLECT; m_wcnt = 0; end
                    else m_wcnt++;
                end
            end
            M_COLLECT: begin
                if (!run_en) begin m_state = M_IDLE; m_bcnt = 0; m_rct = 0; end
                else if (bit_valid) begin
                    rct_new = (m_rct == 0 || bit_in != m_prev) ? 1 : m_rct + 1;
                    m_prev = bit_in;
                    if (rct_new == LIMIT) begin
                        m_state = M_ALARM; m_alarm = 1'b1; m_reseed = 1'b1;
                        exp_q.delete(); pop = 1'b0; m_bcnt = 0; m_rct = 0;
                    end else begin
                        m_rct = rct_new;
                        m_word[m_bcnt] = bit_in;
                        m_bcnt++;
                        if (m_bcnt == W) begin done = 1'b1; m_bcnt = 0; end
                    end
                end
            end
            default: if (alarm_clr) begin m_state = M_IDLE; m_alarm = 1'b0; end
        endcase
        if (pop) void'(exp_q.pop_front());
        if (done) begin
            if (exp_q.size() < D) exp_q.push_back(m_word);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("fill", fill, exp_q.size());
        checkOutput("out_valid", out_valid, exp_q.size() > 0);
        checkOutput("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : '0);
        checkOutput("drop_cnt", drop_cnt, m_drop);
        checkOutput("alarm", alarm, m_alarm);
        checkOutput("reseed_req", reseed_req, m_reseed);
    endtask

    task automatic applyStimulus(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        stepCycle();
    endtask

    task automatic sendWord(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) applyStimulus(w[i]);
    endtask

    // Bits 3 and 4 always differ, so no run of equal bits exceeds 8
    function automatic logic [W-1:0] makeWord();
        logic [W-1:0] w;
        w = W'($urandom);
        w[4] = ~w[3];
        return w;
    endfunction

    task automatic idleCycles(input int n);
        bit_valid = 1'b0;
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        rst = 1'b1; run_en = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        out_ready = 1'b0; alarm_clr = 1'b0;
        stepCycle();
        rst = 1'b0;
        checkOutput("reset_fill", fill, 0);
        checkOutput("reset_valid", out_valid, 0);

        // Warm-up discard and LSB-first packing
        run_en = 1'b1;
        idleCycles(1);
        applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        sendWord(8'h4D);
        checkOutput("t1_data", out_data, 8'h4D);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_fill", fill, 1);
        out_ready = 1'b1;
        idleCycles(1);
        out_ready = 1'b0;

        // Overflow drop, then in-order drain
        for (int i = 0; i < 5; i++) begin
            sent[i] = makeWord();
            sendWord(sent[i]);
        end
        checkOutput("t2_fill", fill, 4);
        checkOutput("t2_drop", drop_cnt, 1);
        bit_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_order", out_data, sent[i]);
            out_ready = 1'b1;
            stepCycle();
        end
        out_ready = 1'b0;
        checkOutput("t2_empty", out_valid, 0);

        // Full FIFO with a pop on the completing edge
        for (int i = 0; i < 4; i++) sendWord(makeWord());
        prior_word = makeWord();
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) out_ready = 1'b1;
            applyStimulus(prior_word[i]);
        end
        out_ready = 1'b0;
        checkOutput("t5_fill", fill, 4);
        checkOutput("t5_drop", drop_cnt, 1);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) sendWord(makeWord());
        checkOutput("t2_drop_sat", drop_cnt, 255);
        out_ready = 1'b1;
        alarm_clr = 1'b1;
        idleCycles(4);
        alarm_clr = 1'b0;

        // Repetition-count health test
        applyStimulus(1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("t3_no_alarm", alarm, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        checkOutput("t3_alarm", alarm, 1);
        checkOutput("t3_reseed", reseed_req, 1);
        checkOutput("t3_fill", fill, 0);
        applyStimulus(1'b0);
        checkOutput("t3_reseed_pulse", reseed_req, 0);
        alarm_clr = 1'b1;
        idleCycles(1);
        alarm_clr = 1'b0;
        checkOutput("t3_clear", alarm, 0);

        // Leaving RUN mid-word repeats the warm-up
        out_ready = 1'b0;
        idleCycles(1);
        for (int i = 0; i < WU; i++) applyStimulus(1'b1);
        prior_word = makeWord();
        sendWord(prior_word);
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        applyStimulus(1'b0); applyStimulus(1'b1);
        run_en = 1'b0;
        idleCycles(1);
        run_en = 1'b1;
        idleCycles(1);
        applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
        sendWord(8'hA5);
        checkOutput("t4_fill", fill, 2);
        checkOutput("t4_head", out_data, prior_word);
        out_ready = 1'b1;
        idleCycles(1);
        checkOutput("t4_second", out_data, 8'hA5);
        idleCycles(1);
        out_ready = 1'b0;

        // Reset mid-word and during ALARM
        sendWord(makeWord());
        applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b0);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("t6_fill", fill, 0);
        checkOutput("t6_drop", drop_cnt, 0);
        checkOutput("t6_data", out_data, 0);
        idleCycles(1);
        for (int i = 0; i < WU; i++) applyStimulus(1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1);
        checkOutput("t6_in_alarm", alarm, 1);
        applyStimulus(1'b1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("t6_alarm_rst", alarm, 0);
        idleCycles(1);
        for (int i = 0; i < WU; i++) applyStimulus(1'b1);
        sendWord(8'h3C);
        checkOutput("t6_restart", out_data, 8'h3C);
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trng_word_ctrl.md
Name: trng_word_ctrl

Overview:
Post-processing controller for the TRNG core. It sits downstream of the LOAD/INIT/RUN sequencer and qualifies the raw bit stream during RUN: discards warm-up bits, runs a repetition-count health test, packs bits into words and buffers them in a small FIFO behind a valid/ready interface. On a health failure it flushes its buffered output, raises an alarm and requests a core reseed, which restarts the LOAD sequence.

Parameters:
WIDTH, 32, output word width in bits (>=2)
DEPTH, 4, output FIFO depth in words (power of 2, >=2)
WARMUP, 64, number of valid bits discarded after each entry to RUN (>=0)
RCT_LIMIT, 32, consecutive identical accepted bits that trigger an alarm (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
run_en  in  1  core in RUN state
bit_in  in  1  raw TRNG bit
bit_valid  in  1  bit_in is a fresh sample this cycle
out_data  out  WIDTH  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head word
fill  out  clog2(DEPTH)+1  FIFO occupancy
drop_cnt  out  8  words dropped on full FIFO, saturating at 255
alarm  out  1  health test failed, sticky until alarm_clr
alarm_clr  in  1  clears alarm
reseed_req  out  1  one-cycle pulse requesting core restart

Behaviour:
- Reset (rst=1 at edge): state IDLE; out_valid=0, out_data=0, fill=0, drop_cnt=0, alarm=0, reseed_req=0; bit, warm-up and RCT counters and shift register cleared. Overrides all other inputs, including mid-word or during ALARM.
- Accepted bit = bit_valid & run_en in the relevant state; bits with bit_valid=0 are ignored.
- States:
  - IDLE: waits for run_en=1 -> WARMUP (or COLLECT if WARMUP=0) next cycle.
  - WARMUP: counts accepted bits; the WARMUP-th accepted bit is discarded and moves to COLLECT. run_en=0 -> IDLE, count reset.
  - COLLECT: accepted bits shifted in LSB-first (first bit -> bit 0). After the WIDTH-th bit, the word is pushed at that edge; out_valid rises the following cycle if FIFO was empty (1-cycle latency). run_en=0 -> IDLE; partial word discarded, FIFO contents kept; re-entry repeats WARMUP.
  - ALARM: entered when the RCT counter reaches RCT_LIMIT. On entry edge: alarm=1, reseed_req=1 for exactly one cycle, FIFO flushed (fill=0, out_valid=0), partial word and counters cleared; the bit that hit the limit is not packed. Bits ignored. alarm_clr=1 -> IDLE, alarm=0 next cycle. alarm_clr outside ALARM has no effect.
- RCT: operates on COLLECT accepted bits only. Counter=1 on first bit after entry, +1 if bit equals previous accepted bit, else reset to 1. Reset on leaving COLLECT.
- FIFO: pop when out_valid & out_ready. Push when word completes and fill<DEPTH, or fill==DEPTH with a pop in the same cycle (both succeed, fill unchanged). Word completing with fill==DEPTH and no pop is dropped; drop_cnt+1, saturating at 255. Push and pop when not full: fill unchanged, order preserved. out_data holds head, or 0 when empty.
- No combinational path from out_ready to out_valid.

Test Plan:
(WIDTH=8, DEPTH=4, WARMUP=4, RCT_LIMIT=16, bit_valid=1 every cycle unless stated)
1. run_en=1, 4 arbitrary bits then 1,0,1,1,0,0,1,0 -> out_data=8'h4D, out_valid=1 one cycle after 8th bit, fill=1; first 4 bits never appear.
2. out_ready=0, generate 5 words -> fill=4, drop_cnt=1, then out_ready=1 returns words 1-4 in order; 300 dropped words -> drop_cnt=255.
3. 15 ones then a 0 -> no alarm. 16 consecutive ones -> alarm=1 and reseed_req=1 for one cycle on the next edge, fill=0, out_valid=0. alarm_clr=1 -> IDLE, alarm=0.
4. run_en low after 5 COLLECT bits, then high -> 4 warm-up bits discarded again, next word built from fresh bits only; prior FIFO words intact.
5. FIFO full, out_ready=1 on the cycle a word completes -> pop and push both succeed, fill stays 4, drop_cnt unchanged.
6. rst=1 mid-word and again in ALARM -> all outputs zero next cycle, state IDLE, alarm cleared without alarm_clr.
